// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared types and encodings for the multi-cycle RV32I control path
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JALR,
        S_JLINK,
        S_LUI,
        S_ERROR
    } state_t;

    // ALU opcode set, shared with the ALU itself
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    // RV32I major opcodes
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // datapath mux encodings
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_MEMDATA   = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    // immediate format implied by the major opcode; I is the harmless default
    function automatic logic [2:0] imm_src_for(input logic [6:0] op);
        case (op)
            OP_STORE:          return IMM_S;
            OP_BRANCH:         return IMM_B;
            OP_JAL:            return IMM_J;
            OP_LUI, OP_AUIPC:  return IMM_U;
            default:           return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - funct3/funct7 to ALU opcode decode for register and immediate ops
// Ports:
//   funct3      in  IR[14:12]
//   funct7b5    in  IR[30]
//   is_rtype    in  1 when decoding a register-register operation
//   alu_control out ALU opcode
module alu_decoder
    import ctrl_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       is_rtype,
    output logic [3:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (funct3)
            // immediate ops have no SUBI; IR[30] is part of the immediate there
            3'b000:  alu_control = (is_rtype && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_control = ALU_SLL;
            3'b010:  alu_control = ALU_SLT;
            3'b011:  alu_control = ALU_SLTU;
            3'b100:  alu_control = ALU_XOR;
            // SRAI also carries IR[30], so both forms honour it
            3'b101:  alu_control = funct7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  alu_control = ALU_OR;
            3'b111:  alu_control = ALU_AND;
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - main control FSM of the multi-cycle RV32I core
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   opcode/funct3/funct7b5     instruction fields from IR
//   zero                       ALU zero flag, used to resolve branches
//   mem_ready                  memory completes the current access this cycle
//   mem_req/mem_write/adr_src  unified memory port control
//   ir_write/pc_write/reg_write architectural register enables
//   alu_src_a/alu_src_b/result_src/imm_src/alu_control datapath selects
//   illegal_instr/bus_error    sticky error flags
//   instret                    retired-instruction counter
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 0,
    parameter int          CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_write,
    output logic             adr_src,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       result_src,
    output logic [2:0]       imm_src,
    output logic [3:0]       alu_control,
    output logic             illegal_instr,
    output logic             bus_error,
    output logic [CNT_W-1:0] instret
);

    state_t           r_state;
    logic [31:0]      r_tmo_cnt;
    logic             r_illegal;
    logic             r_bus_err;
    logic [CNT_W-1:0] r_instret;

    state_t     w_next;
    logic       w_mem_state;
    logic       w_timeout;
    logic       w_retire;
    logic       w_set_illegal;
    logic       w_taken;
    logic       w_mem_req;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_pc_write;
    logic       w_reg_write;
    logic [3:0] w_dec_alu;

    alu_decoder u_alu_decoder (
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .is_rtype    (r_state == S_EXECR),
        .alu_control (w_dec_alu)
    );

    assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMREAD) ||
                         (r_state == S_MEMWRITE);
    assign w_timeout   = (MEM_TIMEOUT != 0) && w_mem_state && (r_tmo_cnt >= MEM_TIMEOUT);

    // Taken sense per funct3: BEQ/BGE/BGEU branch on zero=1, BNE/BLT/BLTU on zero=0
    assign w_taken = zero ^ (funct3[0] ^ funct3[2]);

    always_comb begin
        w_next        = r_state;
        w_retire      = 1'b0;
        w_set_illegal = 1'b0;
        w_mem_req     = 1'b0;
        w_mem_write   = 1'b0;
        w_ir_write    = 1'b0;
        w_pc_write    = 1'b0;
        w_reg_write   = 1'b0;
        adr_src       = 1'b0;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_RS2;
        result_src    = RES_ALUOUT;
        imm_src       = IMM_I;
        alu_control   = ALU_ADD;
        case (r_state)
            S_FETCH: begin
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                w_mem_req  = !w_timeout;
                if (w_timeout) begin
                    w_next = S_ERROR;
                end else if (mem_ready) begin
                    w_ir_write = 1'b1;
                    w_pc_write = 1'b1;
                    w_next     = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                imm_src   = imm_src_for(opcode);
                case (opcode)
                    OP_LOAD, OP_STORE: w_next = S_MEMADR;
                    OP_RTYPE:          w_next = S_EXECR;
                    OP_ITYPE:          w_next = S_EXECI;
                    OP_BRANCH:         w_next = (funct3[2:1] == 2'b01) ? S_ERROR : S_BRANCH;
                    OP_JAL:            w_next = S_JLINK;
                    OP_JALR:           w_next = S_JALR;
                    OP_LUI:            w_next = S_LUI;
                    // AUIPC: ALUOut already holds oldPC+imm, so write it back directly
                    OP_AUIPC:          w_next = S_ALUWB;
                    default:           w_next = S_ERROR;
                endcase
                w_set_illegal = (w_next == S_ERROR);
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                // loads and stores differ only in opcode bit 5
                w_next    = opcode[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src   = 1'b1;
                w_mem_req = !w_timeout;
                if (w_timeout)      w_next = S_ERROR;
                else if (mem_ready) w_next = S_MEMWB;
            end
            S_MEMWB: begin
                result_src  = RES_MEMDATA;
                w_reg_write = 1'b1;
                w_retire    = 1'b1;
                w_next      = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src     = 1'b1;
                w_mem_req   = !w_timeout;
                w_mem_write = !w_timeout;
                if (w_timeout) begin
                    w_next = S_ERROR;
                end else if (mem_ready) begin
                    w_retire = 1'b1;
                    w_next   = S_FETCH;
                end
            end
            S_EXECR: begin
                alu_src_a   = SRCA_RS1;
                alu_src_b   = SRCB_RS2;
                alu_control = w_dec_alu;
                w_next      = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a   = SRCA_RS1;
                alu_src_b   = SRCB_IMM;
                alu_control = w_dec_alu;
                w_next      = S_ALUWB;
            end
            S_ALUWB: begin
                result_src  = RES_ALUOUT;
                w_reg_write = 1'b1;
                w_retire    = 1'b1;
                w_next      = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a   = SRCA_RS1;
                alu_src_b   = SRCB_RS2;
                result_src  = RES_ALUOUT;
                alu_control = !funct3[2] ? ALU_SUB : (funct3[1] ? ALU_SLTU : ALU_SLT);
                w_pc_write  = w_taken;
                w_retire    = 1'b1;
                w_next      = S_FETCH;
            end
            S_JALR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                w_next    = S_JLINK;
            end
            S_JLINK: begin
                // PC takes the target from ALUOut while the ALU forms the link oldPC+4
                result_src = RES_ALUOUT;
                w_pc_write = 1'b1;
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                w_next     = S_ALUWB;
            end
            S_LUI: begin
                alu_src_a = SRCA_ZERO;
                alu_src_b = SRCB_IMM;
                w_next    = S_ALUWB;
            end
            S_ERROR: w_next = S_ERROR;
            default: w_next = S_FETCH;
        endcase
    end

    // enables are forced low while reset is held so nothing is written mid-reset
    assign mem_req   = w_mem_req   && !reset;
    assign mem_write = w_mem_write && !reset;
    assign ir_write  = w_ir_write  && !reset;
    assign pc_write  = w_pc_write  && !reset;
    assign reg_write = w_reg_write && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_tmo_cnt <= '0;
            r_illegal <= 1'b0;
            r_bus_err <= 1'b0;
            r_instret <= '0;
        end else begin
            r_state <= w_next;
            // clearing on every state change covers entry into each memory state
            if (mem_ready || (w_next != r_state))
                r_tmo_cnt <= '0;
            else if (w_mem_req)
                r_tmo_cnt <= r_tmo_cnt + 32'd1;
            if (w_set_illegal)
                r_illegal <= 1'b1;
            if (w_timeout)
                r_bus_err <= 1'b1;
            if (w_retire)
                r_instret <= r_instret + CNT_W'(1);
        end
    end

    assign illegal_instr = r_illegal;
    assign bus_error     = r_bus_err;
    assign instret       = r_instret;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - randomized self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

    localparam int C_R = 0, C_I = 1, C_LD = 2, C_ST = 3, C_BR = 4;
    localparam int C_JAL = 5, C_JALR = 6, C_LUI = 7, C_AUIPC = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        zero;
    logic        mem_ready;

    logic        mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0]  alu_src_a, alu_src_b, result_src;
    logic [2:0]  imm_src;
    logic [3:0]  alu_control;
    logic        illegal_instr, bus_error;
    logic [31:0] instret;

    logic        mem_req_t, mem_write_t, adr_src_t, ir_write_t, pc_write_t, reg_write_t;
    logic [1:0]  alu_src_a_t, alu_src_b_t, result_src_t;
    logic [2:0]  imm_src_t;
    logic [3:0]  alu_control_t;
    logic        illegal_instr_t, bus_error_t;
    logic [31:0] instret_t;

    wire [4:0] enables = {mem_req, ir_write, pc_write, reg_write, mem_write};

    multicycle_ctrl dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
        .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
        .imm_src(imm_src), .alu_control(alu_control), .illegal_instr(illegal_instr),
        .bus_error(bus_error), .instret(instret)
    );

    multicycle_ctrl #(.MEM_TIMEOUT(4)) dut_tmo (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(1'b0), .mem_req(mem_req_t), .mem_write(mem_write_t),
        .adr_src(adr_src_t), .ir_write(ir_write_t), .pc_write(pc_write_t),
        .reg_write(reg_write_t), .alu_src_a(alu_src_a_t), .alu_src_b(alu_src_b_t),
        .result_src(result_src_t), .imm_src(imm_src_t), .alu_control(alu_control_t),
        .illegal_instr(illegal_instr_t), .bus_error(bus_error_t), .instret(instret_t)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model: instruction-level rules ----------------
    function automatic logic [6:0] op_of(input int c);
        case (c)
            C_R:     return 7'b0110011;
            C_I:     return 7'b0010011;
            C_LD:    return 7'b0000011;
            C_ST:    return 7'b0100011;
            C_BR:    return 7'b1100011;
            C_JAL:   return 7'b1101111;
            C_JALR:  return 7'b1100111;
            C_LUI:   return 7'b0110111;
            default: return 7'b0010111;
        endcase
    endfunction

    // cycles with no wait states
    function automatic int base_latency(input int c);
        case (c)
            C_LD, C_JALR:  return 5;
            C_BR, C_AUIPC: return 3;
            default:       return 4;
        endcase
    endfunction

    function automatic logic [2:0] exp_imm(input int c);
        case (c)
            C_ST:           return 3'b001;
            C_BR:           return 3'b010;
            C_JAL:          return 3'b011;
            C_LUI, C_AUIPC: return 3'b100;
            default:        return 3'b000;
        endcase
    endfunction

    function automatic logic [3:0] exp_alu(input int c, input logic [2:0] f3, input logic f7);
        if (c == C_BR) begin
            case (f3)
                3'b000, 3'b001: return 4'b0001;
                3'b100, 3'b101: return 4'b1000;
                default:        return 4'b1001;
            endcase
        end
        case (f3)
            3'b000:  return (c == C_R && f7) ? 4'b0001 : 4'b0000;
            3'b001:  return 4'b0101;
            3'b010:  return 4'b1000;
            3'b011:  return 4'b1001;
            3'b100:  return 4'b0100;
            3'b101:  return f7 ? 4'b0111 : 4'b0110;
            3'b110:  return 4'b0011;
            default: return 4'b0010;
        endcase
    endfunction

    function automatic logic exp_taken(input logic [2:0] f3, input logic z);
        case (f3)
            3'b000:  return z;
            3'b001:  return !z;
            3'b100:  return !z;
            3'b101:  return z;
            3'b110:  return !z;
            default: return z;
        endcase
    endfunction

    // Runs one instruction starting in its fetch cycle (posedge+1); wf/wm are the
    // wait cycles before mem_ready in the fetch and data accesses.
    task automatic run_instr(input int c, input logic [2:0] f3, input logic f7,
                             input logic z, input int wf, input int wm);
        int          lat, n_ir, n_pc, n_rw, n_mw, burst, waited, exp_pc;
        logic [31:0] start;
        logic [3:0]  alu_pre, alu_last;
        logic [1:0]  rs_last;
        logic        rw_last, pc_last, tk, exp_rw;
        logic [2:0]  imm_dec;
        string       nm;
        nm = $sformatf("i%0d/c%0d/f%0d", n_checks, c, f3);
        start = instret;
        opcode = op_of(c); funct3 = f3; funct7b5 = f7;
        lat = base_latency(c) + wf + ((c == C_LD || c == C_ST) ? wm : 0);
        n_ir = 0; n_pc = 0; n_rw = 0; n_mw = 0; burst = 0; waited = 0;
        alu_pre = 'x; alu_last = 'x; rs_last = 'x; rw_last = 'x; pc_last = 'x; imm_dec = 'x;
        for (int cyc = 0; cyc < lat; cyc++) begin
            zero = z;
            mem_ready = mem_req && (waited >= ((burst == 0) ? wf : wm));
            #1;
            n_ir += int'(ir_write); n_pc += int'(pc_write);
            n_rw += int'(reg_write); n_mw += int'(mem_write);
            if (cyc == wf + 1) imm_dec = imm_src;
            if (cyc == lat - 2) alu_pre = alu_control;
            if (cyc == lat - 1) begin
                alu_last = alu_control; rs_last = result_src;
                rw_last = reg_write; pc_last = pc_write;
            end
            if (mem_req) begin
                if (mem_ready) begin burst++; waited = 0; end
                else waited++;
            end
            @(posedge clk); #1;
        end
        mem_ready = 1'b0;
        tk = (c == C_BR) && exp_taken(f3, z);
        exp_rw = (c != C_ST) && (c != C_BR);
        exp_pc = 1 + ((c == C_JAL || c == C_JALR) ? 1 : 0) + (tk ? 1 : 0);
        check({nm, " instret"}, instret, start + 32'd1);
        check({nm, " ir_cnt"}, n_ir, 1);
        check({nm, " pc_cnt"}, n_pc, exp_pc);
        check({nm, " rw_cnt"}, n_rw, exp_rw);
        check({nm, " mw_cnt"}, n_mw, (c == C_ST) ? wm + 1 : 0);
        check({nm, " imm_src"}, imm_dec, exp_imm(c));
        check({nm, " next_fetch"}, {mem_req, adr_src, mem_write}, 3'b100);
        check({nm, " flags"}, {illegal_instr, bus_error}, 2'b00);
        if (exp_rw) begin
            check({nm, " rw_last"}, rw_last, 1'b1);
            check({nm, " rs_last"}, rs_last, (c == C_LD) ? 2'b01 : 2'b00);
        end
        if (c == C_R || c == C_I)
            check({nm, " alu_exec"}, alu_pre, exp_alu(c, f3, f7));
        if (c == C_BR) begin
            check({nm, " alu_br"}, alu_last, exp_alu(c, f3, f7));
            check({nm, " br_taken"}, pc_last, tk);
            check({nm, " rs_br"}, rs_last, 2'b00);
        end
    endtask

    // Illegal instruction from FETCH: flag set, held in ERROR, cleared by a 1-cycle reset.
    task automatic illegal_test(input logic [6:0] op, input logic [2:0] f3, input int hold);
        int bad;
        opcode = op; funct3 = f3; funct7b5 = 1'b0;
        mem_ready = 1'b1; #1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        check($sformatf("illegal set op%0h", op), illegal_instr, 1'b1);
        bad = 0;
        for (int k = 0; k < hold; k++) begin
            mem_ready = 1'($urandom_range(0, 1)); zero = 1'($urandom_range(0, 1));
            #1;
            if (enables != 5'b0 || !illegal_instr) bad++;
            @(posedge clk); #1;
        end
        mem_ready = 1'b0;
        check("error hold", bad, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        check("enables in reset", enables, 5'b0);
        reset = 1'b0; #1;
        check("after reset", {illegal_instr, mem_req, adr_src, instret}, {3'b010, 32'd0});
    endtask

    logic [2:0] br_f3 [6] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int ir_t, rw_seen, c;
        logic [2:0] f3;
        reset = 1'b1; opcode = 7'b0; funct3 = 3'b0; funct7b5 = 1'b0;
        zero = 1'b0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset instret", instret, 32'd0);
        check("reset flags", {illegal_instr, bus_error}, 2'b00);
        check("reset enables", enables, 5'b0);

        // timeout instance sees mem_ready stuck low from its first fetch
        reset = 1'b0; #1;
        ir_t = 0;
        for (int k = 0; k < 8; k++) begin
            ir_t += int'(ir_write_t);
            check($sformatf("tmo mem_req k%0d", k), mem_req_t, k < 4);
            check($sformatf("tmo bus_error k%0d", k), bus_error_t, k >= 5);
            @(posedge clk); #1;
        end
        check("tmo ir_write", ir_t, 0);
        check("tmo disabled", bus_error, 1'b0);

        // directed scenarios
        run_instr(C_R,  3'b000, 1'b1, 1'b0, 0, 0);   // SUB
        run_instr(C_LD, 3'b010, 1'b0, 1'b0, 3, 2);   // load, 10 cycles
        run_instr(C_BR, 3'b001, 1'b0, 1'b0, 0, 0);   // BNE taken
        run_instr(C_BR, 3'b001, 1'b0, 1'b1, 0, 0);   // BNE not taken
        run_instr(C_BR, 3'b111, 1'b0, 1'b1, 0, 0);   // BGEU taken
        run_instr(C_I,  3'b101, 1'b1, 1'b0, 1, 0);   // SRAI
        run_instr(C_I,  3'b000, 1'b1, 1'b0, 0, 0);   // ADDI with IR[30] set
        run_instr(C_ST, 3'b010, 1'b0, 1'b0, 0, 3);
        run_instr(C_JALR, 3'b000, 1'b0, 1'b0, 0, 0);
        run_instr(C_AUIPC, 3'b000, 1'b0, 1'b0, 0, 0);

        for (int i = 0; i < 40; i++) begin
            c  = $urandom_range(0, 8);
            f3 = (c == C_BR) ? br_f3[$urandom_range(0, 5)] : 3'($urandom_range(0, 7));
            run_instr(c, f3, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 3), $urandom_range(0, 3));
        end

        illegal_test(7'b1111111, 3'b000, 20);
        illegal_test(7'b1100011, 3'b010, 3);

        // reset while waiting in MEMREAD: load is abandoned
        rw_seen = 0;
        opcode = 7'b0000011; funct3 = 3'b010;
        mem_ready = 1'b1; #1;
        rw_seen += int'(reg_write);
        @(posedge clk); #1;
        mem_ready = 1'b0;
        repeat (2) begin
            rw_seen += int'(reg_write);
            @(posedge clk); #1;
        end
        check("memread reached", {mem_req, adr_src}, 2'b11);
        reset = 1'b1; mem_ready = 1'b1; #1;
        check("memread reset enables", enables, 5'b0);
        @(posedge clk); #1;
        reset = 1'b0; mem_ready = 1'b0; #1;
        check("memread reset fetch", {mem_req, adr_src}, 2'b10);
        for (int k = 0; k < 3; k++) begin
            rw_seen += int'(reg_write);
            @(posedge clk); #1;
        end
        check("memread reset rw", rw_seen, 0);
        check("memread reset instret", instret, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
